// File: rtl/wired_bpu_resolve_pkg.sv
// Shared types for the branch-resolve end of the PC-generator protocol:
// per-slot predictions, commit feedback and the fetch-target-queue entry.
package wired_bpu_resolve_pkg;

  localparam int HIST_W = 5;
  localparam int LPHR_W = 2;
  localparam int RAS_W  = 3;

  typedef enum logic [1:0] {
    NPC    = 2'd0,
    IMM    = 2'd1,
    CALL   = 2'd2,
    RETURN = 2'd3
  } bpu_target_type_e;

  typedef struct packed {
    logic              tid;
    logic [31:0]       predict_pc;
    logic              taken;
    bpu_target_type_e  target_type;
    logic              dir_type;
    logic [HIST_W-1:0] history;
    logic [LPHR_W-1:0] lphr;
    logic [RAS_W-1:0]  ras_ptr;
  } bpu_predict_t;

  typedef struct packed {
    logic              redirect;
    logic [31:0]       pc;
    logic              tid;
    logic              miss;
    logic              need_update;
    logic              ras_miss_type;
    logic [31:0]       true_target;
    logic [31:0]       btb_target;
    logic              true_taken;
    bpu_target_type_e  true_target_type;
    logic              true_conditional_jmp;
    logic [HIST_W-1:0] history;
    logic [LPHR_W-1:0] lphr;
    logic [RAS_W-1:0]  ras_ptr;
  } bpu_correct_t;

  typedef struct packed {
    logic [31:3]        pc;
    logic [1:0]         mask;
    bpu_predict_t [1:0] predict;
  } ftq_entry_t;

  function automatic logic is_ras_type(input bpu_target_type_e t);
    return (t == CALL) || (t == RETURN);
  endfunction

endpackage

// File: rtl/wired_bpu_resolve_if.sv
// Prediction, resolve and feedback channels between pcgen/commit and the resolver.
interface wired_bpu_resolve_if;
  import wired_bpu_resolve_pkg::*;

  // Prediction channel: a packet transfers on a clk edge where p_valid_i and
  // p_ready_o are both high; p_ready_o depends only on FTQ occupancy, never on
  // p_valid_i. Resolve is valid-only: r_valid_i is never back-pressured.
  logic               p_valid_i;
  logic               p_ready_o;
  logic [31:0]        p_pc_i;
  logic [1:0]         p_mask_i;
  bpu_predict_t [1:0] p_predict_i;

  logic               r_valid_i;
  logic               r_slot_i;
  logic               r_last_i;
  logic               r_taken_i;
  logic [31:0]        r_target_i;
  bpu_target_type_e   r_type_i;
  logic               r_cond_i;

  bpu_correct_t       p_correct_o;
  logic               empty_o;

  modport master (
    output p_valid_i, p_pc_i, p_mask_i, p_predict_i,
    output r_valid_i, r_slot_i, r_last_i, r_taken_i, r_target_i, r_type_i, r_cond_i,
    input  p_ready_o, p_correct_o, empty_o
  );

  modport slave (
    input  p_valid_i, p_pc_i, p_mask_i, p_predict_i,
    input  r_valid_i, r_slot_i, r_last_i, r_taken_i, r_target_i, r_type_i, r_cond_i,
    output p_ready_o, p_correct_o, empty_o
  );
endinterface

// File: rtl/wired_bpu_ftq.sv
// In-order fetch-target queue: circular buffer with one write port and a head read.
module wired_bpu_ftq
  import wired_bpu_resolve_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  ftq_entry_t wr_data,
  input  logic       retire,
  input  logic       flush,
  output ftq_entry_t head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  // Extra MSB is the wrap bit distinguishing full from empty.
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_ptr;
  ftq_entry_t  mem [DEPTH];

  assign full  = (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]) && (rd_ptr[AW] != wr_ptr[AW]);
  assign empty = (rd_ptr == wr_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (retire) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/wired_bpu_resolve.sv
// Holds predicted fetch packets until commit resolves them and returns
// redirect / predictor-update feedback to pcgen one cycle later.
module wired_bpu_resolve
  import wired_bpu_resolve_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input logic                clk,
  input logic                rst,
  wired_bpu_resolve_if.slave bus
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("wired_bpu_resolve: DEPTH must be a power of two >= 2");
  end
  if (RESET_PC[2:0] != 3'b000) begin : g_bad_reset_pc
    $error("wired_bpu_resolve: RESET_PC must be 8-byte aligned");
  end

  ftq_entry_t   head;
  ftq_entry_t   wr_data;
  logic         full;
  logic         empty;
  logic         tier_q;
  bpu_predict_t pr;
  logic         miss;
  logic         need_update;
  logic         ras_miss_type;
  logic         redirect_now;
  logic         enq;
  logic         retire;
  bpu_correct_t correct_d;
  bpu_correct_t correct_q;
  logic         unused_ok;

  always_comb begin
    pr            = head.predict[bus.r_slot_i];
    miss          = (pr.taken != bus.r_taken_i) ||
                    (bus.r_taken_i && (pr.predict_pc != bus.r_target_i));
    need_update   = (bus.r_type_i != NPC) || (pr.target_type != NPC);
    ras_miss_type = !miss && (pr.target_type != bus.r_type_i) &&
                    (is_ras_type(pr.target_type) || is_ras_type(bus.r_type_i));
    redirect_now  = bus.r_valid_i && miss;
    // Packets from the old tier are accepted on the wire but never stored.
    enq           = bus.p_valid_i && !full && (bus.p_predict_i[0].tid == tier_q) &&
                    !redirect_now;
    retire        = bus.r_valid_i && bus.r_last_i && !miss;
  end

  always_comb begin
    wr_data         = '0;
    wr_data.pc      = bus.p_pc_i[31:3];
    wr_data.mask    = bus.p_mask_i;
    wr_data.predict = bus.p_predict_i;
  end

  always_comb begin
    correct_d                      = '0;
    correct_d.redirect             = miss;
    correct_d.pc                   = {head.pc, bus.r_slot_i, 2'b00};
    correct_d.tid                  = tier_q ^ miss;
    correct_d.miss                 = miss;
    correct_d.need_update          = need_update;
    correct_d.ras_miss_type        = ras_miss_type;
    correct_d.true_target          = bus.r_target_i;
    correct_d.btb_target           = bus.r_target_i;
    correct_d.true_taken           = bus.r_taken_i;
    correct_d.true_target_type     = bus.r_type_i;
    correct_d.true_conditional_jmp = bus.r_cond_i;
    correct_d.history              = pr.history;
    correct_d.lphr                 = pr.lphr;
    correct_d.ras_ptr              = pr.ras_ptr;
  end

  wired_bpu_ftq #(.DEPTH(DEPTH)) u_ftq (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (enq),
    .wr_data (wr_data),
    .retire  (retire),
    .flush   (redirect_now),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tier_q    <= 1'b0;
      correct_q <= '0;
    end else begin
      if (redirect_now) tier_q <= ~tier_q;
      correct_q <= bus.r_valid_i ? correct_d : '0;
    end
  end

  assign bus.p_correct_o = correct_q;
  assign bus.p_ready_o   = !full;
  assign bus.empty_o     = empty;

  // Mask, tid and dir_type travel with the entry but do not affect resolution.
  assign unused_ok = ^{head.mask, pr.tid, pr.dir_type};

endmodule
